// File: rtl/bind_stim_pkg.sv
// Shared types and constants for the bind_stim_gen stimulus generator.
package bind_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] P1_STEP   = 8'd1;
  localparam logic [7:0] P2_STEP   = 8'd2;
  localparam logic [7:0] P3_STEP   = 8'd3;

endpackage

// File: rtl/stim_lfsr8.sv
// One combinational step of an 8-bit Galois LFSR (right shift, taps 0xB8).
module stim_lfsr8
  import bind_stim_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);

endmodule

// File: rtl/bind_stim_gen.sv
// Valid/ready byte-triple generator feeding a bound checker; counts accepted items.
// Define STIM_LFSR_EN to step p3 with an LFSR instead of +3.
module bind_stim_gen
  import bind_stim_pkg::*;
#(
  parameter int         NUM_ITEMS = 4,
  parameter int         GAP       = 0,
  parameter logic [7:0] P1_BASE   = 8'h04,
  parameter logic [7:0] P2_BASE   = 8'h05,
  parameter logic [7:0] P3_BASE   = 8'h06
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       p_ready,
  output logic       p_valid,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] count,
  output logic       busy,
  output logic       done
);

  // The local parameter GAP hides the enum literal, so states are package-qualified.
  localparam logic [7:0] LAST_COUNT = NUM_ITEMS[7:0];
  localparam logic [3:0] GAP_LEN    = GAP[3:0];

`ifdef STIM_LFSR_EN
  localparam logic [7:0] P3_SEED = (P3_BASE == 8'h00) ? 8'h01 : P3_BASE;
`else
  localparam logic [7:0] P3_SEED = P3_BASE;
`endif

  state_t     state, state_d;
  logic [7:0] p1_d, p2_d, p3_d, count_d, p3_next;
  logic [3:0] gap_cnt, gap_cnt_d;
  logic       handshake;

`ifdef STIM_LFSR_EN
  stim_lfsr8 u_lfsr (
    .cur (p3),
    .nxt (p3_next)
  );
`else
  assign p3_next = p3 + P3_STEP;
`endif

  assign p_valid   = (state == bind_stim_pkg::SEND);
  assign busy      = (state == bind_stim_pkg::SEND) || (state == bind_stim_pkg::GAP);
  assign done      = (state == bind_stim_pkg::DONE);
  assign handshake = p_valid && p_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state;
    p1_d      = p1;
    p2_d      = p2;
    p3_d      = p3;
    count_d   = count;
    gap_cnt_d = gap_cnt;
    unique case (state)
      bind_stim_pkg::IDLE, bind_stim_pkg::DONE: begin
        if (start) begin
          state_d = bind_stim_pkg::SEND;
          p1_d    = P1_BASE;
          p2_d    = P2_BASE;
          p3_d    = P3_SEED;
          count_d = 8'd0;
        end
      end
      bind_stim_pkg::SEND: begin
        if (handshake) begin
          count_d = count + 8'd1;
          if (count_d == LAST_COUNT) begin
            state_d = bind_stim_pkg::DONE;  // last payload stays visible in DONE
          end else begin
            p1_d = p1 + P1_STEP;
            p2_d = p2 + P2_STEP;
            p3_d = p3_next;
            if (GAP_LEN != 4'd0) begin
              state_d   = bind_stim_pkg::GAP;
              gap_cnt_d = GAP_LEN - 4'd1;
            end
          end
        end
      end
      bind_stim_pkg::GAP: begin
        if (gap_cnt == 4'd0) state_d = bind_stim_pkg::SEND;
        else                 gap_cnt_d = gap_cnt - 4'd1;
      end
      default: state_d = bind_stim_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and non-blocking like every other state update; it wins over any handshake.
    if (!rst_n) begin
      state   <= bind_stim_pkg::IDLE;
      p1      <= P1_BASE;
      p2      <= P2_BASE;
      p3      <= P3_SEED;
      count   <= 8'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_d;
      p1      <= p1_d;
      p2      <= p2_d;
      p3      <= p3_d;
      count   <= count_d;
      gap_cnt <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_bind_stim_gen.sv
// Directed self-checking bench for bind_stim_gen: default, GAP=2 and wrap instances.
module tb_bind_stim_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, ready_a, start_g, ready_g, start_w, ready_w;

  logic       a_valid, a_busy, a_done;
  logic [7:0] a_p1, a_p2, a_p3, a_count;
  logic       g_valid, g_busy, g_done;
  logic [7:0] g_p1, g_p2, g_p3, g_count;
  logic       w_valid, w_busy, w_done;
  logic [7:0] w_p1, w_p2, w_p3, w_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_p3 [4];

  always #5 clk = ~clk;

  bind_stim_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .p_ready(ready_a),
    .p_valid(a_valid), .p1(a_p1), .p2(a_p2), .p3(a_p3),
    .count(a_count), .busy(a_busy), .done(a_done)
  );

  bind_stim_gen #(.GAP(2)) u_gap (
    .clk(clk), .rst_n(rst_n), .start(start_g), .p_ready(ready_g),
    .p_valid(g_valid), .p1(g_p1), .p2(g_p2), .p3(g_p3),
    .count(g_count), .busy(g_busy), .done(g_done)
  );

  bind_stim_gen #(.NUM_ITEMS(3), .P1_BASE(8'hFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .p_ready(ready_w),
    .p_valid(w_valid), .p1(w_p1), .p2(w_p2), .p3(w_p3),
    .count(w_count), .busy(w_busy), .done(w_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;
    int lows;
    logic [7:0] p1_exp;

`ifdef STIM_LFSR_EN
    exp_p3 = '{8'h06, 8'h03, 8'hB9, 8'hE4};
`else
    exp_p3 = '{8'h06, 8'h09, 8'h0C, 8'h0F};
`endif
    rst_n = 1'b0;
    start_a = 1'b0; ready_a = 1'b0;
    start_g = 1'b0; ready_g = 1'b0;
    start_w = 1'b0; ready_w = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_p1", a_p1, 8'h04);
    check("rst_p2", a_p2, 8'h05);
    check("rst_p3", a_p3, 8'h06);
    check("rst_valid", a_valid, 1'b0);
    check("rst_count", a_count, 8'd0);
    check("rst_done", a_done, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic run, p_ready always high
    start_a = 1'b1; ready_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_valid%0d", i), a_valid, 1'b1);
      check($sformatf("basic_busy%0d", i), a_busy, 1'b1);
      check($sformatf("basic_p1_%0d", i), a_p1, 8'h04 + 8'(i));
      check($sformatf("basic_p2_%0d", i), a_p2, 8'h05 + 8'(2 * i));
      check($sformatf("basic_p3_%0d", i), a_p3, exp_p3[i]);
      step();
    end
    check("basic_done", a_done, 1'b1);
    check("basic_count", a_count, 8'd4);
    check("basic_valid_end", a_valid, 1'b0);
    check("basic_busy_end", a_busy, 1'b0);
    check("basic_hold_p1", a_p1, 8'h07);
    check("basic_hold_p3", a_p3, exp_p3[3]);

    // Backpressure on item 1
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid%0d", i), a_valid, 1'b1);
      check($sformatf("bp_p1_%0d", i), a_p1, 8'h05);
      check($sformatf("bp_p2_%0d", i), a_p2, 8'h07);
      check($sformatf("bp_p3_%0d", i), a_p3, exp_p3[1]);
      check($sformatf("bp_count%0d", i), a_count, 8'd1);
      step();
    end
    ready_a = 1'b1;
    step();
    check("bp_count_after", a_count, 8'd2);
    check("bp_p1_after", a_p1, 8'h06);
    repeat (2) step();
    check("bp_done", a_done, 1'b1);
    check("bp_count_final", a_count, 8'd4);

    // GAP=2: two idle cycles between handshakes, 10 cycles first-valid..done
    start_g = 1'b1; ready_g = 1'b1;
    step();
    start_g = 1'b0;
    cycles = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gap_valid%0d", i), g_valid, 1'b1);
      check($sformatf("gap_p1_%0d", i), g_p1, 8'h04 + 8'(i));
      step();
      cycles++;
      if (i < 3) begin
        lows = 0;
        while (!g_valid && lows < 20) begin
          check($sformatf("gap_busy%0d_%0d", i, lows), g_busy, 1'b1);
          lows++;
          step();
          cycles++;
        end
        check($sformatf("gap_lows%0d", i), lows, 2);
      end
    end
    check("gap_done", g_done, 1'b1);
    check("gap_total", cycles, 10);

    // Wrap of p1 and restart from DONE
    start_w = 1'b1; ready_w = 1'b1;
    step();
    start_w = 1'b0;
    p1_exp = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_p1_%0d", i), w_p1, p1_exp);
      p1_exp = p1_exp + 8'd1;
      step();
    end
    check("wrap_done", w_done, 1'b1);
    check("wrap_count", w_count, 8'd3);
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    check("restart_p1", w_p1, 8'hFE);
    check("restart_count", w_count, 8'd0);
    check("restart_valid", w_valid, 1'b1);
    check("restart_done", w_done, 1'b0);

    // Start ignored while busy; reset mid-handshake wins
    start_a = 1'b1; ready_a = 1'b0;
    step();
    start_a = 1'b0;
    check("mid_valid", a_valid, 1'b1);
    check("mid_done_cleared", a_done, 1'b0);
    start_a = 1'b1; ready_a = 1'b1;
    step();
    start_a = 1'b0; ready_a = 1'b0;
    check("busy_start_count", a_count, 8'd1);
    check("busy_start_p1", a_p1, 8'h05);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("busy_start_hold_p1", a_p1, 8'h05);
    check("busy_start_hold_count", a_count, 8'd1);
    rst_n = 1'b0;
    step();
    check("midrst_valid", a_valid, 1'b0);
    check("midrst_p1", a_p1, 8'h04);
    check("midrst_p2", a_p2, 8'h05);
    check("midrst_count", a_count, 8'd0);
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_done", a_done, 1'b0);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
